mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified 32-bit word memory port between two requesters: the instruction fetch path (I) and the load/store data path (D).
- Sits between the processor's fetch/data stages and a variable-latency memory using a req/ready handshake.
- Grants one requester at a time, holds memory-side signals stable until ready, and returns read data with a one-cycle ack pulse.
- The core uses the ack pulses as its stall release.

Parameters:
- TIMEOUT, 255: maximum wait cycles for M_ready before abort; range 1..1023.
- ERR_DATA, 32'h0000_0000: read data returned on an aborted or misaligned transaction.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- I_req  in  1  fetch request; held high until I_ack.
- I_addr  in  32  fetch byte address.
- I_rdata  out  32  fetched instruction.
- I_ack  out  1  one-cycle completion pulse for the fetch.
- D_req  in  1  data request; held high until D_ack.
- D_we  in  1  1 = store, 0 = load.
- D_addr  in  32  data byte address.
- D_wdata  in  32  store data.
- D_rdata  out  32  load data.
- D_ack  out  1  one-cycle completion pulse for the data access.
- M_req  out  1  memory request.
- M_we  out  1  memory write enable.
- M_addr  out  32  memory byte address.
- M_wdata  out  32  memory write data.
- M_rdata  in  32  memory read data; valid while M_ready is high.
- M_ready  in  1  memory completion; sampled only while M_req is high.
- Busy  out  1  high while in I_WAIT or D_WAIT.
- Err  out  1  sticky: a timeout or misalignment has occurred.

Behaviour:
- Reset (synchronous, wins over all other events, including mid-transaction):
  - State goes to IDLE.
  - M_req, M_we, I_ack, D_ack, Busy and Err go to 0.
  - M_addr, M_wdata, I_rdata and D_rdata go to 0.
  - last_grant goes to I.
  - Any in-flight memory request is abandoned with no ack.
- States: IDLE, I_WAIT, D_WAIT. All outputs are registered.
- IDLE arbitration on the clock edge:
  - Eligible requests are I_req and D_req, excluding any port whose ack is high this cycle. This prevents re-grant while the requester is still deasserting.
  - Only D eligible: grant D. Only I eligible: grant I.
  - Both eligible: grant the port that is not last_grant (round robin).
  - On grant:
    - Latch the address into M_addr.
    - For D, latch D_we into M_we and D_wdata into M_wdata; for I, M_we = 0.
    - Set M_req = 1 and update last_grant.
    - Move to the matching WAIT state.
- Misaligned grant (granted addr[1:0] != 0):
  - No memory access; M_req stays 0 and the state stays IDLE.
  - Next cycle: the granted ack = 1, rdata = ERR_DATA, Err = 1.
- WAIT state:
  - M_req, M_we, M_addr and M_wdata are held constant.
  - A wait counter increments from 0 each cycle.
  - Requester inputs are ignored. A dropped req does not cancel the transaction; the ack still pulses.
- Completion (M_ready = 1 sampled in WAIT):
  - Next cycle: M_req = 0 and state = IDLE.
  - The granted ack = 1 for exactly one cycle.
  - On a read, the granted rdata is loaded from M_rdata. On a write (M_we = 1), rdata is unchanged.
- Latency: request sampled at edge e, M_req high from e+1. With M_ready high in the first WAIT cycle, ack is high in cycle e+2. Back-to-back grants therefore cost 3 cycles minimum.
- rdata hold: each rdata register holds its value until that port's next ack.
- Timeout: if the counter reaches TIMEOUT with no M_ready:
  - Abort: M_req = 0, state = IDLE.
  - Ack pulse with rdata = ERR_DATA; Err = 1.
  - M_ready arriving after the abort is ignored.
- Err: sticky; cleared only by RESET.
- Busy: equals (state != IDLE).
- Counter width: 10 bits. The counter clears on entry to IDLE.

Test Plan:
- Single fetch: I_req=1, I_addr=0x0000_0040, M_ready tied 1, M_rdata=0x2008_0005 -> M_req high 1 cycle with M_addr=0x40 and M_we=0; I_ack pulses 2 cycles after the request edge; I_rdata=0x2008_0005.
- Store with 3-cycle memory: D_req=1, D_we=1, D_addr=0x100, D_wdata=0xCAFE_F00D, M_ready high on the 3rd WAIT cycle -> M_* stable for 3 cycles; D_ack a single pulse; D_rdata unchanged; I_ack=0.
- Contention: I_req and D_req both held high from reset, M_ready=1 -> grants alternate D, I, D, I (last_grant resets to I); each ack is one cycle; no double grant while a req is held through its ack cycle.
- Timeout: TIMEOUT=4, D load, M_ready held 0 -> M_req drops after 4 WAIT cycles; D_ack=1 with D_rdata=ERR_DATA; Err=1 and stays 1; a later M_ready pulse is ignored.
- Misaligned: I_addr=0x0000_0042 -> M_req never asserts; I_ack next cycle with I_rdata=ERR_DATA; Err=1.
- Reset mid-transaction: RESET=1 for 1 cycle during D_WAIT -> next cycle M_req=0, Busy=0, no D_ack, Err=0, all rdata=0; a fresh I_req afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit word memory port between the instruction
// fetch requester (I) and the load/store requester (D). One requester is
// granted at a time (round robin on conflict); memory-side signals are held
// until M_ready, and completion is reported with a one-cycle ack pulse.
// Misaligned requests and memory timeouts complete with ERR_DATA and set
// the sticky Err flag.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_req,
  input  logic [31:0] I_addr,
  output logic [31:0] I_rdata,
  output logic        I_ack,
  input  logic        D_req,
  input  logic        D_we,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_wdata,
  output logic [31:0] D_rdata,
  output logic        D_ack,
  output logic        M_req,
  output logic        M_we,
  output logic [31:0] M_addr,
  output logic [31:0] M_wdata,
  input  logic [31:0] M_rdata,
  input  logic        M_ready,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  // Counter value of the last WAIT cycle before the transaction is aborted.
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 32'd1);

  // Word accesses only: the two low address bits must be zero.
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

  state_t      state;
  logic [9:0]  wait_cnt;
  logic        last_grant;

  logic        i_elig;
  logic        d_elig;
  logic        any_elig;
  logic        pick_d;
  logic [31:0] pick_addr;

  // Arbitration: a port whose ack is pulsing is still deasserting its request, so it is not eligible.
  always_comb begin
    i_elig   = I_req & ~I_ack;
    d_elig   = D_req & ~D_ack;
    any_elig = i_elig | d_elig;
    if (i_elig && d_elig) begin
      pick_d = (last_grant == GRANT_I);
    end else begin
      pick_d = d_elig;
    end
    if (pick_d) begin
      pick_addr = D_addr;
    end else begin
      pick_addr = I_addr;
    end
  end

  // Main FSM: grant in IDLE, hold the memory request in WAIT, complete or abort, drive registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      wait_cnt   <= 10'd0;
      last_grant <= GRANT_I;
      M_req      <= 1'b0;
      M_we       <= 1'b0;
      M_addr     <= 32'h0000_0000;
      M_wdata    <= 32'h0000_0000;
      I_rdata    <= 32'h0000_0000;
      D_rdata    <= 32'h0000_0000;
      I_ack      <= 1'b0;
      D_ack      <= 1'b0;
      Busy       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      I_ack <= 1'b0;
      D_ack <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 10'd0;
          if (any_elig) begin
            last_grant <= pick_d;
            if (word_aligned(pick_addr[1:0])) begin
              M_req  <= 1'b1;
              M_addr <= pick_addr;
              Busy   <= 1'b1;
              if (pick_d) begin
                M_we    <= D_we;
                M_wdata <= D_wdata;
                state   <= D_WAIT;
              end else begin
                M_we    <= 1'b0;
                state   <= I_WAIT;
              end
            end else begin
              // Misaligned: no memory access, fail the granted port next cycle.
              Err <= 1'b1;
              if (pick_d) begin
                D_ack   <= 1'b1;
                D_rdata <= ERR_DATA;
              end else begin
                I_ack   <= 1'b1;
                I_rdata <= ERR_DATA;
              end
            end
          end
        end

        I_WAIT, D_WAIT: begin
          if (M_ready) begin
            state    <= IDLE;
            wait_cnt <= 10'd0;
            M_req    <= 1'b0;
            M_we     <= 1'b0;
            Busy     <= 1'b0;
            if (state == D_WAIT) begin
              D_ack <= 1'b1;
              if (!M_we) begin
                D_rdata <= M_rdata;
              end
            end else begin
              I_ack <= 1'b1;
              if (!M_we) begin
                I_rdata <= M_rdata;
              end
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Timeout: abandon the memory request and fail the granted port.
            state    <= IDLE;
            wait_cnt <= 10'd0;
            M_req    <= 1'b0;
            M_we     <= 1'b0;
            Busy     <= 1'b0;
            Err      <= 1'b1;
            if (state == D_WAIT) begin
              D_ack   <= 1'b1;
              D_rdata <= ERR_DATA;
            end else begin
              I_ack   <= 1'b1;
              I_rdata <= ERR_DATA;
            end
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end

        default: begin
          state    <= IDLE;
          wait_cnt <= 10'd0;
          M_req    <= 1'b0;
          M_we     <= 1'b0;
          Busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (expected M_req window, ack cycle, rdata, Err).
module tb_mem_arbiter;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I_req = 1'b0;
  logic [31:0] I_addr = 32'h0;
  logic [31:0] I_rdata;
  logic        I_ack;
  logic        D_req = 1'b0;
  logic        D_we = 1'b0;
  logic [31:0] D_addr = 32'h0;
  logic [31:0] D_wdata = 32'h0;
  logic [31:0] D_rdata;
  logic        D_ack;
  logic        M_req;
  logic        M_we;
  logic [31:0] M_addr;
  logic [31:0] M_wdata;
  logic [31:0] M_rdata = 32'h0;
  logic        M_ready = 1'b0;
  logic        Busy;
  logic        Err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_i_rdata = 32'h0;
  logic [31:0] m_d_rdata = 32'h0;
  logic        m_err = 1'b0;

  mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_req(I_req), .I_addr(I_addr), .I_rdata(I_rdata), .I_ack(I_ack),
    .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata), .D_ack(D_ack),
    .M_req(M_req), .M_we(M_we), .M_addr(M_addr), .M_wdata(M_wdata),
    .M_rdata(M_rdata), .M_ready(M_ready), .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_i_rdata = 32'h0;
    m_d_rdata = 32'h0;
    m_err     = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_m_req"}, M_req, 1'b0);
    chk1({tag, "_busy"}, Busy, 1'b0);
    chk1({tag, "_i_ack"}, I_ack, 1'b0);
    chk1({tag, "_d_ack"}, D_ack, 1'b0);
    chk32({tag, "_i_rdata"}, I_rdata, m_i_rdata);
    chk32({tag, "_d_rdata"}, D_rdata, m_d_rdata);
    chk1({tag, "_err"}, Err, m_err);
  endtask

  // One transaction from a single requester; the memory answers lat cycles into WAIT
  // (lat >= TO means it never answers). Expected timeline comes from the model.
  task automatic run_txn(input bit port_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdat, input int lat);
    bit          aligned;
    bit          tmo;
    int          n;
    int          ackc;
    logic [31:0] exp_rd;
    aligned = (addr[1:0] == 2'b00);
    tmo     = aligned && (lat >= int'(TO));
    n       = !aligned ? 0 : (tmo ? int'(TO) : lat + 1);
    ackc    = n + 1;
    exp_rd  = (!aligned || tmo) ? ERRD : ((port_d && we) ? m_d_rdata : rdat);
    if (port_d) begin
      D_req = 1'b1; D_we = we; D_addr = addr; D_wdata = wdata;
    end else begin
      I_req = 1'b1; I_addr = addr;
    end
    M_ready = 1'b0;
    for (int c = 1; c <= ackc + 1; c++) begin
      tick();
      chk1("m_req", M_req, c <= n);
      chk1("busy", Busy, c <= n);
      if (c <= n) begin
        chk32("m_addr", M_addr, addr);
        chk1("m_we", M_we, port_d && we);
        if (port_d && we) begin
          chk32("m_wdata", M_wdata, wdata);
        end
      end
      chk1("i_ack", I_ack, !port_d && (c == ackc));
      chk1("d_ack", D_ack, port_d && (c == ackc));
      if (c == ackc) begin
        if (port_d) m_d_rdata = exp_rd;
        else        m_i_rdata = exp_rd;
        if (!aligned || tmo) m_err = 1'b1;
      end
      chk32("i_rdata", I_rdata, m_i_rdata);
      chk32("d_rdata", D_rdata, m_d_rdata);
      chk1("err", Err, m_err);
      M_ready = (c <= n) && !tmo && (c - 1 == lat);
      M_rdata = M_ready ? rdat : $urandom();
      if (c == ackc + 1) begin
        I_req = 1'b0;
        D_req = 1'b0;
      end
    end
    M_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    bit          rp;
    bit          rw;

    // reset state
    RESET = 1'b1;
    tick();
    tick();
    model_reset();
    chk_idle_outputs("reset");
    chk32("reset_m_addr", M_addr, 32'h0);
    chk32("reset_m_wdata", M_wdata, 32'h0);
    chk1("reset_m_we", M_we, 1'b0);
    RESET = 1'b0;

    // single fetch, memory ready in first WAIT cycle
    run_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 0);
    // store with memory ready on the 3rd WAIT cycle: D_rdata unchanged
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h1111_2222, 2);
    // load finishing on the last WAIT cycle before timeout
    run_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h3333_4444, int'(TO) - 1);

    // contention: both requests held from reset, grants alternate D, I, D, I
    RESET = 1'b1;
    I_req = 1'b1; I_addr = 32'h0000_0200;
    D_req = 1'b1; D_addr = 32'h0000_0300; D_we = 1'b0;
    M_ready = 1'b1; M_rdata = 32'h1234_5678;
    tick();
    tick();
    RESET = 1'b0;
    model_reset();
    for (int c = 1; c <= 8; c++) begin
      bit gd;
      tick();
      gd = (((c - 1) / 2) % 2) == 0;
      if (c % 2 == 1) begin
        chk1("cont_m_req", M_req, 1'b1);
        chk32("cont_m_addr", M_addr, gd ? 32'h0000_0300 : 32'h0000_0200);
        chk1("cont_i_ack", I_ack, 1'b0);
        chk1("cont_d_ack", D_ack, 1'b0);
      end else begin
        chk1("cont_m_req", M_req, 1'b0);
        chk1("cont_i_ack", I_ack, !gd);
        chk1("cont_d_ack", D_ack, gd);
        if (gd) m_d_rdata = 32'h1234_5678;
        else    m_i_rdata = 32'h1234_5678;
        chk32("cont_i_rdata", I_rdata, m_i_rdata);
        chk32("cont_d_rdata", D_rdata, m_d_rdata);
      end
      if (c == 8) begin
        I_req = 1'b0;
        D_req = 1'b0;
      end
    end
    M_ready = 1'b0;
    tick();
    chk_idle_outputs("cont_end");

    // misaligned fetch
    run_txn(1'b0, 1'b0, 32'h0000_0042, 32'h0, 32'h5555_6666, 0);
    // timeout on a D load, then a late M_ready that must be ignored
    run_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h7777_8888, 10);
    M_ready = 1'b1;
    M_rdata = 32'h9999_AAAA;
    tick();
    M_ready = 1'b0;
    chk_idle_outputs("late_ready");
    tick();
    chk_idle_outputs("late_ready2");

    // reset in the middle of a D transaction
    D_req = 1'b1; D_we = 1'b0; D_addr = 32'h0000_0400;
    tick();
    chk1("mid_m_req", M_req, 1'b1);
    tick();
    chk1("mid_busy", Busy, 1'b1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    D_req = 1'b0;
    model_reset();
    chk_idle_outputs("mid_reset");
    tick();
    chk_idle_outputs("mid_reset2");
    run_txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'hABCD_0123, 1);

    // randomized transactions
    for (int k = 0; k < 60; k++) begin
      ra = $urandom();
      ra[1:0] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rp = 1'($urandom_range(0, 1));
      rw = rp && ($urandom_range(0, 1) == 1);
      run_txn(rp, rw, ra, $urandom(), $urandom(), int'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
